// File: rtl/tap_accum_ctrl_pkg.sv
// rtl/tap_accum_ctrl_pkg.sv - shared widths and FSM encoding for the tap accumulator
package tap_accum_ctrl_pkg;

  localparam int TAC_W     = 26;
  localparam int TAC_NMAX  = 16;
  localparam int TAC_CNT_W = $clog2(TAC_NMAX) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } tac_state_e;

endpackage

// File: rtl/adder.sv
// rtl/adder.sv - combinational W-bit signed adder, wraps modulo 2^W
module adder #(
  parameter int W = 26
) (
  input  logic signed [W-1:0] din1,
  input  logic signed [W-1:0] din2,
  output logic signed [W-1:0] dout
);

  assign dout = din1 + din2;

endmodule

// File: rtl/tap_accum_ctrl.sv
// rtl/tap_accum_ctrl.sv - accumulates a programmed number of tap products and
// presents the sum on a valid/ready output.
module tap_accum_ctrl
  import tap_accum_ctrl_pkg::*;
#(
  parameter int W    = TAC_W,
  parameter int NMAX = TAC_NMAX
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [$clog2(NMAX)-1:0]   num_taps,
  input  logic                      prod_valid,
  input  logic signed [W-1:0]       prod_data,
  output logic                      prod_ready,
  output logic                      sum_valid,
  output logic signed [W-1:0]       sum_data,
  input  logic                      sum_ready,
  output logic                      busy
);

  localparam int TW = $clog2(NMAX);
  localparam int CW = TW + 1;

  tac_state_e         state_q, state_d;
  logic signed [W-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               sum_valid_q;
  logic signed [W-1:0] add_out;
  logic [CW-1:0]      load_cnt;

  adder #(.W(W)) u_adder (
    .din1 (acc_q),
    .din2 (prod_data),
    .dout (add_out)
  );

  // A zero tap count encodes the full NMAX taps.
  assign load_cnt = (num_taps == '0) ? CW'(NMAX) : {1'b0, num_taps};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = load_cnt;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (prod_valid) begin
          acc_d = add_out;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (sum_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sum_valid_q <= (state_d == DONE);
    end
  end

  assign prod_ready = (state_q == ACCUM);
  assign busy       = (state_q != IDLE);
  assign sum_valid  = sum_valid_q;
  assign sum_data   = acc_q;

endmodule

// File: tb/tb_tap_accum_ctrl.sv
// tb/tb_tap_accum_ctrl.sv - directed and randomized checks of tap_accum_ctrl against a sum model
module tb_tap_accum_ctrl;

  localparam int W    = 26;
  localparam int NMAX = 16;
  localparam int TW   = $clog2(NMAX);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [TW-1:0]        num_taps;
  logic                 prod_valid;
  logic signed [W-1:0]  prod_data;
  logic                 prod_ready;
  logic                 sum_valid;
  logic signed [W-1:0]  sum_data;
  logic                 sum_ready;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  logic signed [W-1:0] prods[$];
  logic signed [W-1:0] last_sum;

  tap_accum_ctrl #(.W(W), .NMAX(NMAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_taps   (num_taps),
    .prod_valid (prod_valid),
    .prod_data  (prod_data),
    .prod_ready (prod_ready),
    .sum_valid  (sum_valid),
    .sum_data   (sum_data),
    .sum_ready  (sum_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected result: plain arithmetic sum of the product list, wrapped to W bits.
  function automatic logic signed [W-1:0] model_sum();
    longint total = 0;
    foreach (prods[i]) total += longint'(prods[i]);
    return total[W-1:0];
  endfunction

  // One accumulation: nt is the num_taps field, prods holds the products.
  // restart_at >= 0 pulses start (num_taps=3) alongside that product.
  task automatic run_accum(input int nt, input int gap_pct, input int hold, input int restart_at);
    int n;
    logic signed [W-1:0] exp;
    n   = (nt == 0) ? NMAX : nt;
    exp = model_sum();
    start    = 1'b1;
    num_taps = nt[TW-1:0];
    step();
    start = 1'b0;
    chk("busy_after_start", W'(busy), W'(1));
    chk("ready_in_accum", W'(prod_ready), W'(1));
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < 6 && $urandom_range(0, 99) < gap_pct; g++) begin
        prod_valid = 1'b0;
        prod_data  = W'($urandom);
        step();
        chk("gap_no_sum_valid", W'(sum_valid), W'(0));
        chk("gap_still_ready", W'(prod_ready), W'(1));
      end
      prod_valid = 1'b1;
      prod_data  = prods[i];
      if (i == restart_at) begin
        start    = 1'b1;
        num_taps = TW'(3);
      end
      step();
      start = 1'b0;
      if (i < n - 1) chk("no_early_sum_valid", W'(sum_valid), W'(0));
    end
    prod_valid = 1'b0;
    chk("sum_valid_after_last", W'(sum_valid), W'(1));
    chk("sum_data", sum_data, exp);
    chk("ready_low_in_done", W'(prod_ready), W'(0));
    chk("busy_in_done", W'(busy), W'(1));
    for (int h = 0; h < hold; h++) begin
      sum_ready = 1'b0;
      start     = h[0];
      num_taps  = TW'(3);
      step();
      chk("hold_sum_valid", W'(sum_valid), W'(1));
      chk("hold_sum_data", sum_data, exp);
    end
    sum_ready = 1'b1;
    start     = 1'b1;
    step();
    start     = 1'b0;
    sum_ready = 1'b0;
    chk("sum_valid_falls", W'(sum_valid), W'(0));
    chk("idle_after_handshake", W'(busy), W'(0));
    step();
    chk("start_at_handshake_ignored", W'(busy), W'(0));
    last_sum = exp;
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    num_taps   = '0;
    prod_valid = 1'b0;
    prod_data  = '0;
    sum_ready  = 1'b0;
    step();
    step();
    chk("rst_prod_ready", W'(prod_ready), W'(0));
    chk("rst_sum_valid", W'(sum_valid), W'(0));
    chk("rst_sum_data", sum_data, W'(0));
    chk("rst_busy", W'(busy), W'(0));
    rst = 1'b0;
    step();

    prods = '{26'sd10, -26'sd3, 26'sd7, 26'sd100};
    run_accum(4, 0, 0, -1);
    chk("four_tap_114", last_sum, W'(114));

    prods.delete();
    for (int i = 0; i < NMAX; i++) prods.push_back(26'sd1);
    run_accum(0, 40, 1, -1);
    chk("nmax_taps_16", last_sum, W'(16));

    prods = '{26'sh1FFFFFF, 26'sd1};
    run_accum(2, 0, 0, -1);
    chk("wrap_value", last_sum, 26'h2000000);

    prods = '{W'($urandom), W'($urandom), W'($urandom)};
    run_accum(3, 0, 5, -1);

    // Reset in the middle of a 4-tap accumulation.
    start    = 1'b1;
    num_taps = TW'(4);
    step();
    start      = 1'b0;
    prod_valid = 1'b1;
    prod_data  = 26'sd55;
    step();
    prod_data  = 26'sd66;
    step();
    prod_valid = 1'b0;
    rst        = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", W'(busy), W'(0));
    chk("midrst_acc", sum_data, W'(0));
    chk("midrst_ready", W'(prod_ready), W'(0));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("midrst_no_sum_valid", W'(sum_valid), W'(0));
    end
    prods = '{-26'sd5};
    run_accum(1, 0, 0, -1);
    chk("after_rst_minus5", last_sum, -26'sd5);

    prods = '{26'sd1, 26'sd2, 26'sd3, 26'sd4, 26'sd5};
    run_accum(5, 20, 0, 1);
    chk("restart_ignored_15", last_sum, W'(15));

    for (int r = 0; r < 8; r++) begin
      int nt;
      int n;
      nt = $urandom_range(0, NMAX - 1);
      n  = (nt == 0) ? NMAX : nt;
      prods.delete();
      for (int i = 0; i < n; i++) prods.push_back(W'($urandom));
      run_accum(nt, 30, $urandom_range(0, 3), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
